// File: rtl/io_output_reg.sv
// rtl/io_output_reg.sv - memory-mapped output ports with strobes and hex display scanner (optional readback: IO_OUT_READBACK_EN)
module io_output_reg #(
    parameter logic [15:0] SCAN_DIV   = 16'd50000,
    parameter int          NUM_DIGITS = 4
) (
    input  logic                  io_clk,
    input  logic                  reset,
    input  logic [31:0]           addr,
    input  logic [31:0]           datain,
    input  logic                  write_io_enable,
    output logic [31:0]           out_port0,
    output logic [31:0]           out_port1,
    output logic [31:0]           out_port2,
    output logic [2:0]            out_upd,
    output logic [31:0]           io_read_data,
    output logic [6:0]            hex_seg,
    output logic [NUM_DIGITS-1:0] hex_an
);

    localparam logic [5:0] SEL_PORT0 = 6'b100000;
    localparam logic [5:0] SEL_PORT1 = 6'b100001;
    localparam logic [5:0] SEL_PORT2 = 6'b100010;
    localparam logic [2:0] IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [31:0]           port0_q, port0_d;
    logic [31:0]           port1_q, port1_d;
    logic [31:0]           port2_q, port2_d;
    logic [2:0]            upd_q, upd_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [2:0]            wr_sel;
    logic [3:0]            nibble;

    // Only addr[7:2] takes part in decoding; the rest is deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Next-state: write decode, strobes, scan counter/index, and display from current index and port 2.
    always_comb begin
        wr_sel[0] = write_io_enable && (addr[7:2] == SEL_PORT0);
        wr_sel[1] = write_io_enable && (addr[7:2] == SEL_PORT1);
        wr_sel[2] = write_io_enable && (addr[7:2] == SEL_PORT2);

        port0_d = wr_sel[0] ? datain : port0_q;
        port1_d = wr_sel[1] ? datain : port1_q;
        port2_d = wr_sel[2] ? datain : port2_q;
        upd_d   = wr_sel;

        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q == SCAN_DIV - 16'd1) begin
            cnt_d = 16'd0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        nibble = port2_q[{idx_q, 2'b00} +: 4];
        seg_d  = hex7(nibble);
        an_d   = ~(NUM_DIGITS'(1) << idx_q);
    end

    // State registers; reset leaves digit 0 selected showing '0'.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            port0_q <= 32'h0;
            port1_q <= 32'h0;
            port2_q <= 32'h0;
            upd_q   <= 3'b000;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            seg_q   <= 7'b1000000;
            an_q    <= ~NUM_DIGITS'(1);
        end else begin
            port0_q <= port0_d;
            port1_q <= port1_d;
            port2_q <= port2_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign out_port0 = port0_q;
    assign out_port1 = port1_q;
    assign out_port2 = port2_q;
    assign out_upd   = upd_q;
    assign hex_seg   = seg_q;
    assign hex_an    = an_q;

`ifdef IO_OUT_READBACK_EN
    // Readback of the output latches through the same address window.
    always_comb begin
        io_read_data = 32'h0;
        case (addr[7:2])
            SEL_PORT0: io_read_data = port0_q;
            SEL_PORT1: io_read_data = port1_q;
            SEL_PORT2: io_read_data = port2_q;
            default:   io_read_data = 32'h0;
        endcase
    end
`else
    assign io_read_data = 32'h0;
`endif

endmodule

// File: doc/io_output_reg.md
Name: io_output_reg

Overview:
- Memory-mapped output-port block for the single-cycle computer; the write-side counterpart of the memory-mapped input-port register.
- CPU store instructions to the I/O window latch data into output registers that drive board outputs (LEDs and similar).
- Output port 2 additionally drives a time-multiplexed hex display via an internal scan counter.
- Emits a one-cycle update strobe per port so downstream logic can detect fresh writes.

Parameters:
- SCAN_DIV, 16'd50000, io_clk cycles per display digit slot (legal range 2..65535).
- NUM_DIGITS, 4, hex digits scanned from out_port2[4*NUM_DIGITS-1:0] (legal range 1..8).

Ports:
- io_clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  CPU data address; only addr[7:2] decoded.
- datain  input  32  CPU store data.
- write_io_enable  input  1  CPU I/O store strobe, sampled at io_clk rising edge.
- out_port0  output  32  output register 0, addr[7:2]=6'b100000 (byte 0x80).
- out_port1  output  32  output register 1, addr[7:2]=6'b100001 (0x84).
- out_port2  output  32  output register 2 and display source, 6'b100010 (0x88).
- out_upd  output  3  bit n pulses one cycle after a write to port n.
- io_read_data  output  32  readback (see Optional Feature).
- hex_seg  output  7  active-low segments {g,f,e,d,c,b,a} of current digit.
- hex_an  output  NUM_DIGITS  active-low one-hot digit select.

Behaviour:
- Reset (async, any time, including mid-scan):
  - out_port0/1/2 = 0; out_upd = 0.
  - Scan counter = 0; digit index = 0.
  - hex_an = ~1 (digit 0 active); hex_seg = pattern for 0 = 7'b1000000.
- Write:
  - At a rising edge with write_io_enable=1 and addr[7:2] matching port n, out_portn <= datain.
  - New value is visible after that edge, i.e. 1-cycle latency.
  - Any other addr[7:2] value, or addr[31:8] contents, causes no register change (only addr[7:2] is decoded).
- Strobe:
  - out_upd[n] <= 1 for exactly the cycle after an accepted write to port n; otherwise 0.
  - Back-to-back writes to the same port hold out_upd[n]=1 continuously.
  - At most one bit is set per cycle.
- Scanner:
  - 16-bit counter increments each cycle and wraps to 0 after reaching SCAN_DIV-1.
  - On that wrap edge, digit index advances by 1, wrapping NUM_DIGITS-1 -> 0.
  - hex_an = ~(1 << index).
  - hex_seg = hex decode of nibble out_port2[4*index+3 : 4*index], digits 0-F.
  - hex_seg and hex_an are registered: they update one cycle after the index or the port changes.
- Same-edge events: a write to port 2 on the edge where the index advances is allowed. The next cycle shows the new index decoding the new out_port2 value.
- Writes never reset or stall the scanner.

Optional Feature:
- IO_OUT_READBACK_EN defined:
  - io_read_data is combinational: out_port0/1/2 for addr[7:2]=100000/100001/100010.
  - Returns 32'h0 for all other addresses.
  - Lets the CPU read back output latches through the same address window.
- Not defined: io_read_data is tied to 32'h0 and no readback mux is built.

Test Plan:
- Assert reset mid-scan (index=2) -> all ports 0, out_upd=0, hex_an=4'b1110, hex_seg=7'b1000000, asynchronously and without waiting for a clock.
- Write 32'hDEADBEEF to 0x80 with write_io_enable=1 -> out_port0=DEADBEEF next cycle, out_upd=3'b001 for one cycle, ports 1/2 unchanged.
- Write 32'h12345678 to 0x8C, and separately to 0x84 with write_io_enable=0 -> no port changes, out_upd stays 0.
- SCAN_DIV=4, out_port2=32'h0000A5C3 -> hex_an steps 1110,1101,1011,0111 every 4 cycles, with hex_seg = 3 (0110000), C (1000110), 5 (0010010), A (0001000).
- Write 32'h0000FFFF to 0x88 on the same edge the index advances -> next cycle hex_seg = F (0001110) for the new digit.
- With IO_OUT_READBACK_EN, write 32'h00000055 to 0x84 then read 0x84 -> io_read_data=32'h55. Read 0x90 -> 32'h0. Without the macro, all reads return 32'h0.
